// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester arbiter in front of a single-port data memory (IDLE/ACCESS FSM).
// Tie-break is fixed priority to requester 0 unless DMEM_ARB_ROUND_ROBIN_EN is defined.
module dmem_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic              err0,
    output logic              err1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_write_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data
);

    localparam int unsigned CMP_W = ADDR_W + 1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              sel1;
    logic              tie_to1;
    logic              accept;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_in_range;
    logic              owner;
    logic              we_q;
    logic              in_range_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    // On a tie, favour whichever requester did not win the previous grant.
    logic last_winner;

    assign tie_to1 = ~last_winner;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_winner <= 1'b1;
        end else if (accept) begin
            last_winner <= sel1;
        end
    end
`else
    assign tie_to1 = 1'b0;
`endif

    assign sel1         = req1 & (~req0 | tie_to1);
    assign sel_we       = sel1 ? we1 : we0;
    assign sel_addr     = sel1 ? addr1 : addr0;
    assign sel_wdata    = sel1 ? wdata1 : wdata0;
    assign sel_in_range = {1'b0, sel_addr} < CMP_W'(DEPTH);
    assign accept       = gnt0 | gnt1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grant only from IDLE; ACCESS always lasts exactly one cycle.
    always_comb begin
        state_next = state;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        if (state == IDLE) begin
            if (!reset && (req0 || req1)) begin
                gnt0       = ~sel1;
                gnt1       = sel1;
                state_next = ACCESS;
            end
        end else begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner      <= 1'b0;
            we_q       <= 1'b0;
            in_range_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            err0       <= 1'b0;
            err1       <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            err0  <= 1'b0;
            err1  <= 1'b0;
            if (accept) begin
                owner      <= sel1;
                we_q       <= sel_we;
                in_range_q <= sel_in_range;
                addr_q     <= sel_addr;
                wdata_q    <= sel_wdata;
            end
            // Completion: pulse the owner's done/err and capture read data.
            if (state == ACCESS) begin
                if (owner) begin
                    done1 <= 1'b1;
                    err1  <= ~in_range_q;
                    if (!we_q && in_range_q) begin
                        rdata1 <= mem_rd_data;
                    end
                end else begin
                    done0 <= 1'b1;
                    err0  <= ~in_range_q;
                    if (!we_q && in_range_q) begin
                        rdata0 <= mem_rd_data;
                    end
                end
            end
        end
    end

    assign mem_addr     = addr_q;
    assign mem_wr_data  = wdata_q;
    assign mem_write_en = (state == ACCESS) & we_q & in_range_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: random transactions against a word-level memory/arbitration model.
// Tie-break expectations follow DMEM_ARB_ROUND_ROBIN_EN when it is defined for the build.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, done0, done1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic        mem_write_en;
    logic [31:0] mem_addr, mem_wr_data, mem_rd_data;

    logic [31:0] mem [256];
    logic        fill;

    logic [31:0] ref_mem [256];
    logic [31:0] ref_rd  [2];
    int          model_last;
    int          pass_cnt;
    int          total_cnt;

    dmem_arbiter dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .err0(err0), .err1(err1), .rdata0(rdata0), .rdata1(rdata1),
        .mem_write_en(mem_write_en), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return 32'(i) * 32'h9E37_79B1 ^ 32'h5A5A_0F0F;
    endfunction

    // Memory behind the arbiter: combinational read, write on the rising edge.
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else if (mem_write_en && mem_addr < 32'd256) begin
            mem[mem_addr[7:0]] <= mem_wr_data;
        end
    end
    assign mem_rd_data = (mem_addr < 32'd256) ? mem[mem_addr[7:0]] : 32'hBAD0_BAD0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic apply_reset();
        req0 = 0; req1 = 0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        ref_rd[0] = '0; ref_rd[1] = '0;
        model_last = 1;
    endtask

    // Drives one transaction from a lone requester and records what the DUT did.
    task automatic txn(input int r, input logic w, input logic [31:0] a, input logic [31:0] d,
                       output int wt, output logic ws, output logic [31:0] wa,
                       output logic [31:0] wd, output logic dn, output logic er,
                       output logic odn, output logic [31:0] rd0, output logic [31:0] rd1);
        if (r == 0) begin req0 = 1; we0 = w; addr0 = a; wdata0 = d; end
        else        begin req1 = 1; we1 = w; addr1 = a; wdata1 = d; end
        wt = 0;
        @(negedge clk);
        while (!(r == 1 ? gnt1 : gnt0) && wt < 20) begin
            @(posedge clk); #1; wt++;
            @(negedge clk);
        end
        model_last = r;
        @(posedge clk); #1;
        req0 = 0; req1 = 0;
        @(negedge clk);
        ws = mem_write_en; wa = mem_addr; wd = mem_wr_data;
        @(posedge clk); #1;
        @(negedge clk);
        dn  = (r == 1) ? done1 : done0;
        er  = (r == 1) ? err1 : err0;
        odn = (r == 1) ? done0 : done1;
        rd0 = rdata0; rd1 = rdata1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        req0 = 1; req1 = 1; we0 = 1; we1 = 1; addr0 = 3; addr1 = 4;
        @(negedge clk);
        total_cnt++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) $display("FAIL reset_gnt: got %b%b expected 00", gnt0, gnt1); else pass_cnt++;
        total_cnt++; if (done0 !== 1'b0 || done1 !== 1'b0) $display("FAIL reset_done: got %b%b expected 00", done0, done1); else pass_cnt++;
        total_cnt++; if (err0 !== 1'b0 || err1 !== 1'b0) $display("FAIL reset_err: got %b%b expected 00", err0, err1); else pass_cnt++;
        total_cnt++; if (rdata0 !== 32'd0 || rdata1 !== 32'd0) $display("FAIL reset_rdata: got %h %h expected 0 0", rdata0, rdata1); else pass_cnt++;
        total_cnt++; if (mem_addr !== 32'd0 || mem_wr_data !== 32'd0) $display("FAIL reset_mem_bus: got %h %h expected 0 0", mem_addr, mem_wr_data); else pass_cnt++;
        total_cnt++; if (mem_write_en !== 1'b0) $display("FAIL reset_we: got %b expected 0", mem_write_en); else pass_cnt++;
        @(posedge clk); #1;
        req0 = 0; req1 = 0;
        reset = 1'b0;
        ref_rd[0] = '0; ref_rd[1] = '0;
        model_last = 1;
    endtask

    task automatic test_basic();
        int wt; logic ws, dn, er, odn; logic [31:0] wa, wd, rd0, rd1;
        txn(0, 1'b1, 32'd5, 32'hDEAD, wt, ws, wa, wd, dn, er, odn, rd0, rd1);
        total_cnt++; if (wt !== 0) $display("FAIL basic_wr_gnt_wait: got %0d expected 0", wt); else pass_cnt++;
        total_cnt++; if (ws !== 1'b1 || wa !== 32'd5 || wd !== 32'hDEAD) $display("FAIL basic_wr_bus: got we=%b addr=%h data=%h expected 1 5 dead", ws, wa, wd); else pass_cnt++;
        total_cnt++; if (dn !== 1'b1 || er !== 1'b0 || odn !== 1'b0) $display("FAIL basic_wr_done: got done=%b err=%b other=%b expected 1 0 0", dn, er, odn); else pass_cnt++;
        ref_mem[5] = 32'hDEAD;
        txn(0, 1'b0, 32'd5, 32'h0, wt, ws, wa, wd, dn, er, odn, rd0, rd1);
        total_cnt++; if (ws !== 1'b0) $display("FAIL basic_rd_we: got %b expected 0", ws); else pass_cnt++;
        total_cnt++; if (dn !== 1'b1 || rd0 !== 32'hDEAD) $display("FAIL basic_rd_data: got done=%b rdata0=%h expected 1 dead", dn, rd0); else pass_cnt++;
        total_cnt++; if (rd1 !== ref_rd[1]) $display("FAIL basic_rd_other: got %h expected %h", rd1, ref_rd[1]); else pass_cnt++;
        ref_rd[0] = 32'hDEAD;
    endtask

    // Shared expectation for lone-requester traffic, derived from the word-level model.
    task automatic run_checked(input string tag, input int r, input logic w,
                               input logic [31:0] a, input logic [31:0] d);
        int wt; logic ws, dn, er, odn; logic [31:0] wa, wd, rd0, rd1;
        logic oor; logic [31:0] exp_rd [2];
        oor = (a >= 32'd256);
        exp_rd[0] = ref_rd[0]; exp_rd[1] = ref_rd[1];
        if (!w && !oor) exp_rd[r] = ref_mem[a[7:0]];
        txn(r, w, a, d, wt, ws, wa, wd, dn, er, odn, rd0, rd1);
        total_cnt++; if (wt !== 0) $display("FAIL %s_gnt_wait: got %0d expected 0", tag, wt); else pass_cnt++;
        total_cnt++; if (dn !== 1'b1 || odn !== 1'b0) $display("FAIL %s_done: got done=%b other=%b expected 1 0", tag, dn, odn); else pass_cnt++;
        total_cnt++; if (er !== oor) $display("FAIL %s_err: got %b expected %b addr=%h", tag, er, oor, a); else pass_cnt++;
        total_cnt++; if (ws !== (w && !oor)) $display("FAIL %s_mem_we: got %b expected %b", tag, ws, (w && !oor)); else pass_cnt++;
        if (w && !oor) begin
            total_cnt++; if (wa !== a || wd !== d) $display("FAIL %s_mem_bus: got %h %h expected %h %h", tag, wa, wd, a, d); else pass_cnt++;
            ref_mem[a[7:0]] = d;
        end
        total_cnt++; if (rd0 !== exp_rd[0] || rd1 !== exp_rd[1]) $display("FAIL %s_rdata: got %h %h expected %h %h", tag, rd0, rd1, exp_rd[0], exp_rd[1]); else pass_cnt++;
        ref_rd[0] = exp_rd[0]; ref_rd[1] = exp_rd[1];
    endtask

    task automatic test_out_of_range();
        run_checked("oor_rd256", 1, 1'b0, 32'd256, 32'h0);
        run_checked("oor_wr256", 1, 1'b1, 32'd256, 32'h1234_5678);
        run_checked("oor_rdhuge", 0, 1'b0, 32'hFFFF_FFF0, 32'h0);
        run_checked("edge_rd255", 1, 1'b0, 32'd255, 32'h0);
        run_checked("edge_wr255", 1, 1'b1, 32'd255, 32'hCAFE_F00D);
        run_checked("edge_rd255b", 1, 1'b0, 32'd255, 32'h0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 30; k++) begin
            int r; logic w; logic [31:0] a; int pick;
            r = int'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            pick = int'($urandom_range(0, 9));
            if (pick < 7)      a = $urandom_range(0, 15);
            else if (pick < 9) a = $urandom_range(0, 255);
            else               a = $urandom_range(256, 1000);
            run_checked("rand", r, w, a, $urandom);
        end
    endtask

    task automatic test_tie();
        int cnt, cyc, win, expw;
        logic [31:0] a [2];
        apply_reset();
        a[0] = $urandom_range(0, 255); a[1] = $urandom_range(0, 255);
        req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = a[0]; addr1 = a[1];
        cnt = 0; cyc = 0;
        while (cnt < 4 && cyc < 40) begin
            @(negedge clk);
            if (gnt0 || gnt1) begin
                total_cnt++; if (gnt0 && gnt1) $display("FAIL tie_exclusive: got gnt0=%b gnt1=%b expected one", gnt0, gnt1); else pass_cnt++;
                win  = gnt1 ? 1 : 0;
                expw = RR ? 1 - model_last : 0;
                total_cnt++; if (win !== expw) $display("FAIL tie_order[%0d]: got %0d expected %0d", cnt, win, expw); else pass_cnt++;
                model_last = win;
                ref_rd[win] = ref_mem[a[win][7:0]];
                cnt++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        req0 = 0; req1 = 0;
        total_cnt++; if (cnt !== 4) $display("FAIL tie_grant_count: got %0d expected 4", cnt); else pass_cnt++;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total_cnt++; if (rdata0 !== ref_rd[0] || rdata1 !== ref_rd[1]) $display("FAIL tie_rdata: got %h %h expected %h %h", rdata0, rdata1, ref_rd[0], ref_rd[1]); else pass_cnt++;
    endtask

    task automatic test_reset_during_access();
        logic [31:0] old;
        int seen;
        old = ref_mem[7];
        req0 = 1; we0 = 1; addr0 = 32'd7; wdata0 = ~old;
        @(negedge clk);
        total_cnt++; if (gnt0 !== 1'b1) $display("FAIL abort_gnt: got %b expected 1", gnt0); else pass_cnt++;
        @(posedge clk); #1;
        req0 = 0;
        @(negedge clk);
        total_cnt++; if (mem_write_en !== 1'b1) $display("FAIL abort_we_before: got %b expected 1", mem_write_en); else pass_cnt++;
        reset = 1'b1;
        #1;
        total_cnt++; if (mem_write_en !== 1'b0) $display("FAIL abort_we_after: got %b expected 0", mem_write_en); else pass_cnt++;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        ref_rd[0] = '0; ref_rd[1] = '0;
        model_last = 1;
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done0 !== 1'b0) seen++;
            @(posedge clk); #1;
        end
        total_cnt++; if (seen !== 0) $display("FAIL abort_no_done: got %0d done cycles expected 0", seen); else pass_cnt++;
        total_cnt++; if (mem[7] !== old) $display("FAIL abort_mem7: got %h expected %h", mem[7], old); else pass_cnt++;
        req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 32'd7; addr1 = 32'd3;
        @(negedge clk);
        total_cnt++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) $display("FAIL abort_next_gnt: got %b%b expected 10", gnt0, gnt1); else pass_cnt++;
        @(posedge clk); #1;
        req0 = 0; req1 = 0;
        model_last = 0;
        ref_rd[0] = old;
        @(posedge clk); #1;
        @(negedge clk);
        total_cnt++; if (done0 !== 1'b1 || rdata0 !== old) $display("FAIL abort_readback: got done=%b rdata0=%h expected 1 %h", done0, rdata0, old); else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic exp_g, exp_d;
        a = $urandom_range(0, 255);
        req1 = 1; we1 = 0; addr1 = a;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            exp_g = (k % 2 == 0);
            exp_d = (k >= 2) && (k % 2 == 0);
            total_cnt++; if (gnt1 !== exp_g || gnt0 !== 1'b0) $display("FAIL b2b_gnt[%0d]: got %b%b expected 0%b", k, gnt0, gnt1, exp_g); else pass_cnt++;
            total_cnt++; if (done1 !== exp_d) $display("FAIL b2b_done[%0d]: got %b expected %b", k, done1, exp_d); else pass_cnt++;
            if (exp_d) begin
                total_cnt++; if (rdata1 !== ref_mem[a[7:0]]) $display("FAIL b2b_rdata[%0d]: got %h expected %h", k, rdata1, ref_mem[a[7:0]]); else pass_cnt++;
            end
            @(posedge clk); #1;
        end
        req1 = 0;
        model_last = 1;
        ref_rd[1] = ref_mem[a[7:0]];
        @(posedge clk); #1;
    endtask

    initial begin
        pass_cnt = 0; total_cnt = 0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        reset = 1'b0; fill = 1'b1;
        model_last = 1;
        ref_rd[0] = '0; ref_rd[1] = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        fill = 1'b0;
        test_reset();
        test_basic();
        test_out_of_range();
        test_random();
        test_tie();
        test_reset_during_access();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameters SHALL be as follows.
- ADDR_W, default 32: address width.
- DATA_W, default 32: data width.
- DEPTH, default 256: number of valid memory words.
REQ-002 Ports SHALL be as follows; there is one clock, and reset is asynchronous, active-high.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0 / req1  in  1  requester 0/1 access request.
- we0 / we1  in  1  requester 0/1 write (1) or read (0).
- addr0 / addr1  in  ADDR_W  requester word address.
- wdata0 / wdata1  in  DATA_W  requester write data.
- gnt0 / gnt1  out  1  request accepted this cycle (combinational).
- done0 / done1  out  1  one-cycle completion pulse.
- err0 / err1  out  1  out-of-range flag, valid with done.
- rdata0 / rdata1  out  DATA_W  read data, valid with done on reads.
- mem_write_en  out  1  to memory write enable.
- mem_addr  out  ADDR_W  to memory address.
- mem_wr_data  out  DATA_W  to memory write data.
- mem_rd_data  in  DATA_W  from memory, combinational read.

Function
REQ-003 The FSM SHALL have two states, IDLE and ACCESS.
REQ-004 gnt0/gnt1 SHALL be asserted only in IDLE, at most one at a time, and only for a requester whose req is high.
REQ-005 A transaction SHALL be accepted at the rising edge where gnt is high, and the FSM SHALL then move IDLE->ACCESS while registering we, addr, wdata and the owner ID.
REQ-006 In ACCESS, the block SHALL drive mem_addr/mem_wr_data from the registers and drive mem_write_en = registered we AND in-range.
- The memory commits the write at the edge that ends ACCESS.
REQ-007 At the edge that ends ACCESS, the block SHALL latch mem_rd_data into the owner's rdata register (reads only) and move to IDLE.
REQ-008 The owner's done SHALL pulse high for exactly the one cycle after ACCESS, and the non-owner's done SHALL stay low.
- Latency is accept edge N -> done high in cycle N+2.
REQ-009 A new request MAY be granted in the same cycle done pulses, so throughput is one transaction per 2 cycles.
REQ-010 An address >= DEPTH SHALL be out of range.
- mem_write_en stays low, rdata is unchanged, and err pulses together with done.
REQ-011 Outside ACCESS, mem_write_en SHALL be 0, and mem_addr/mem_wr_data SHALL hold their last values.
REQ-012 Requests arriving while in ACCESS SHALL be ignored until IDLE, with no queuing.
- A requester must hold req until granted.
REQ-013 The rdata outputs SHALL retain their last read value until the next completed read by the same requester.

Reset
REQ-014 Asserting reset at any time SHALL immediately force IDLE.
- mem_write_en=0; gnt0/1=0 except as REQ-004 permits after reset is released; done0/1=0; err0/1=0.
- rdata0/1=0, mem_addr=0, mem_wr_data=0.
- last_winner=1, so requester 0 wins the first tie.
REQ-015 Reset asserted during ACCESS SHALL abort the transaction: no memory write and no done pulse.

Configuration
REQ-016 Macro DMEM_ARB_ROUND_ROBIN_EN SHALL select the tie-break policy.
- Defined: on simultaneous requests the winner is the requester not granted last, and last_winner updates on every grant.
- Undefined: requester 0 always wins ties (fixed priority), and last_winner is unused.
- A lone request is granted immediately under both policies.

Verification
REQ-017 Basic write then read: req0, we0=1, addr0=5, wdata0=0xDEAD -> gnt0 in cycle 0, mem_write_en=1 with mem_addr=5 in cycle 1, done0 in cycle 2; then a read of addr 5 -> rdata0=0xDEAD with done0.
REQ-018 Tie, round-robin defined: req0 and req1 held high for 4 transactions -> grant order 0,1,0,1. With the macro undefined -> 0,0,0,0.
REQ-019 Out of range: req1 read at addr1=256 -> done1 and err1 pulse together, mem_write_en never high, rdata1 unchanged; the same check at addr1=255 -> err1=0.
REQ-020 Reset during ACCESS: req0 write to addr 7, reset asserted mid-ACCESS -> mem_write_en falls immediately, no done0, memory word 7 unchanged, and the next grant goes to requester 0.
REQ-021 Back-to-back: req1 held high continuously -> gnt1 every second cycle and done1 every second cycle, never two grants in consecutive cycles.
